// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Combinational add/sub/logic slice: result, carry-out and signed overflow.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_sa;
  logic           w_sb;

  // Bit WIDTH of the difference is the borrow for SUB.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign w_sa   = i_a[WIDTH-1];
  assign w_sb   = i_b[WIDTH-1];

  always_comb begin
    o_res   = '0;
    o_carry = i_cin;
    o_ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa);
      end
      OP_SUB: begin
        o_res   = w_diff[WIDTH-1:0];
        o_carry = w_diff[WIDTH];
        o_ovf   = (w_sa != w_sb) && (w_diff[WIDTH-1] != w_sa);
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic, bit-serial shifts, shift-add multiply.
// state | meaning
// IDLE  | in_ready high, capture operation on in_valid
// RUN   | one shift or multiply step per cycle, count down to 0
// DONE  | out_valid high, result held until out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  alu_op_e            r_fun;
  alu_op_e            w_op;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNTW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic               r_cout;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;

  logic               w_accept;
  logic               w_multi;
  logic               w_run_last;
  logic               w_fun_shift;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_cu_res;
  logic               w_cu_carry;
  logic               w_cu_ovf;
  logic [WIDTH-1:0]   w_one_res;
  logic               w_one_cout;
  logic               w_one_ovf;
  logic [WIDTH-1:0]   w_sh_val;
  logic               w_sh_bit;
  logic [WIDTH:0]     w_mul_add;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0]   w_run_res;
  logic               w_run_cout;

  assign w_op       = alu_op_e'(fun);
  assign w_shamt    = b[SHW-1:0];
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_multi    = (is_shift(w_op) && (w_shamt != '0)) || ((w_op == OP_MUL) && MUL_EN);
  assign w_run_last = (r_cnt == CNTW'(1));

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .i_op   (w_op),
    .i_a    (a),
    .i_b    (b),
    .i_cin  (cin),
    .o_res  (w_cu_res),
    .o_carry(w_cu_carry),
    .o_ovf  (w_cu_ovf)
  );

  always_comb begin
    w_one_res  = w_cu_res;
    w_one_cout = w_cu_carry;
    w_one_ovf  = w_cu_ovf;
    case (w_op)
      OP_SHL, OP_SHR: begin
        w_one_res  = a;
        w_one_cout = cin;
        w_one_ovf  = 1'b0;
      end
      OP_MUL: begin
        w_one_res  = '0;
        w_one_cout = 1'b0;
        w_one_ovf  = 1'b0;
      end
      default: ;
    endcase
  end

  // Multiplier sits in the low half of r_acc and is consumed LSB first.
  assign w_fun_shift = is_shift(r_fun);
  assign w_sh_val    = (r_fun == OP_SHL) ? {r_a[WIDTH-2:0], 1'b0} : {1'b0, r_a[WIDTH-1:1]};
  assign w_sh_bit    = (r_fun == OP_SHL) ? r_a[WIDTH-1] : r_a[0];
  assign w_mul_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_acc   = {w_mul_add, r_acc[WIDTH-1:1]};
  assign w_run_res   = w_fun_shift ? w_sh_val : w_mul_acc[WIDTH-1:0];
  assign w_run_cout  = w_fun_shift ? w_sh_bit : |w_mul_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)   w_state_nxt = w_multi ? ST_RUN : ST_DONE;
      ST_RUN:  if (w_run_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fun  <= OP_ADD;
      r_a    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_fun <= w_op;
      r_a   <= a;
      r_acc <= {{WIDTH{1'b0}}, b};
      r_cnt <= (w_op == OP_MUL) ? CNTW'(WIDTH) : CNTW'(w_shamt);
      if (!w_multi) begin
        r_out  <= w_one_res;
        r_cout <= w_one_cout;
        r_zero <= (w_one_res == '0);
        r_neg  <= w_one_res[WIDTH-1];
        r_ovf  <= w_one_ovf;
      end
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - CNTW'(1);
      if (w_fun_shift) r_a   <= w_sh_val;
      else             r_acc <= w_mul_acc;
      if (w_run_last) begin
        r_out  <= w_run_res;
        r_cout <= w_run_cout;
        r_zero <= (w_run_res == '0);
        r_neg  <= w_run_res[WIDTH-1];
        r_ovf  <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_out;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: one instance with the multiplier, one without.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fun;
  logic [7:0] a, b;
  logic       cin;

  logic       in_valid1, in_valid0, out_ready1, out_ready0;
  logic       in_ready1, in_ready0, out_valid1, out_valid0;
  logic [7:0] out1, out0;
  logic       cout1, cout0, zero1, zero0, neg1, neg0, ovf1, ovf0;

  int n_checks = 0;
  int n_errors = 0;
  int dut_sel  = 1;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .fun(fun), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid1), .out_ready(out_ready1), .out(out1),
    .cout(cout1), .zero(zero1), .negative(neg1), .overflow(ovf1)
  );

  seq_alu #(.WIDTH(8), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .fun(fun), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid0), .out_ready(out_ready0), .out(out0),
    .cout(cout0), .zero(zero0), .negative(neg0), .overflow(ovf0)
  );

  logic       m_in_ready, m_out_valid, m_cout, m_zero, m_neg, m_ovf;
  logic [7:0] m_out;
  assign m_in_ready  = dut_sel ? in_ready1  : in_ready0;
  assign m_out_valid = dut_sel ? out_valid1 : out_valid0;
  assign m_out       = dut_sel ? out1       : out0;
  assign m_cout      = dut_sel ? cout1      : cout0;
  assign m_zero      = dut_sel ? zero1      : zero0;
  assign m_neg       = dut_sel ? neg1       : neg0;
  assign m_ovf       = dut_sel ? ovf1       : ovf0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (dut_sel != 0) in_valid1 = v;
    else              in_valid0 = v;
  endtask

  task automatic set_ready(input logic v);
    if (dut_sel != 0) out_ready1 = v;
    else              out_ready0 = v;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!m_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input int sel, input logic [2:0] f,
                        input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] e_out, input logic e_cout, input logic e_zero,
                        input logic e_neg, input logic e_ovf, input int e_lat);
    int lat;
    dut_sel = sel;
    @(negedge clk);
    check({tag, ".idle"}, m_in_ready, 1);
    fun = f; a = ia; b = ib; cin = ic;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    fun = 3'b000; a = 8'hA5; b = 8'h5A; cin = ~ic;
    wait_done(lat);
    check({tag, ".valid"}, m_out_valid, 1);
    check({tag, ".lat"}, lat, e_lat);
    check({tag, ".out"}, m_out, e_out);
    check({tag, ".flags"}, {m_cout, m_zero, m_neg, m_ovf}, {e_cout, e_zero, e_neg, e_ovf});
    @(negedge clk);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check({tag, ".ret"}, {m_in_ready, m_out_valid}, 2'b10);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid1 = 0; in_valid0 = 0; out_ready1 = 0; out_ready0 = 0;
    fun = 0; a = 0; b = 0; cin = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", {in_ready1, out_valid1, in_ready0, out_valid0}, 4'b1010);
    check("rst.out", {out1, cout1, zero1, neg1, ovf1}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //      tag         sel fun     a      b      cin out    co z  n  v  lat
    run_op("add_ovf",   1, 3'b000, 8'h7F, 8'h01, 0, 8'h80, 0, 0, 1, 1, 1);
    run_op("sub_zero",  1, 3'b001, 8'h05, 8'h05, 0, 8'h00, 0, 1, 0, 0, 1);
    run_op("sub_borrow",1, 3'b001, 8'h00, 8'h01, 0, 8'hFF, 1, 0, 1, 0, 1);
    run_op("add_cin",   1, 3'b000, 8'hFF, 8'h00, 1, 8'h00, 1, 1, 0, 0, 1);
    run_op("sub_ovf",   1, 3'b001, 8'h80, 8'h01, 0, 8'h7F, 0, 0, 0, 1, 1);
    run_op("and",       1, 3'b010, 8'hF0, 8'h3C, 1, 8'h30, 1, 0, 0, 0, 1);
    run_op("or",        1, 3'b011, 8'h0F, 8'h30, 0, 8'h3F, 0, 0, 0, 0, 1);
    run_op("xor",       1, 3'b100, 8'hAA, 8'hAA, 1, 8'h00, 1, 1, 0, 0, 1);
    run_op("shl3",      1, 3'b101, 8'h81, 8'h03, 0, 8'h08, 0, 0, 0, 0, 4);
    run_op("shr0",      1, 3'b110, 8'h81, 8'h00, 1, 8'h81, 1, 0, 1, 0, 1);
    run_op("shr1",      1, 3'b110, 8'h81, 8'h01, 0, 8'h40, 1, 0, 0, 0, 2);
    run_op("shl7",      1, 3'b101, 8'h02, 8'h07, 0, 8'h00, 1, 1, 0, 0, 8);
    run_op("mul",       1, 3'b111, 8'h10, 8'h11, 0, 8'h10, 1, 0, 0, 0, 9);
    run_op("mul_lo",    1, 3'b111, 8'h0F, 8'h0F, 0, 8'hE1, 0, 0, 1, 0, 9);
    run_op("mul_off",   0, 3'b111, 8'h10, 8'h11, 0, 8'h00, 0, 1, 0, 0, 1);

    // Backpressure: hold DONE while a MUL request is waved at the input
    dut_sel = 1;
    @(negedge clk);
    fun = 3'b000; a = 8'h12; b = 8'h34; cin = 0; in_valid1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0;
    wait_done(lat);
    check("bp.lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fun = 3'b111; a = 8'hFF; b = 8'hFF; cin = 1; in_valid1 = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp.hold", {out_valid1, in_ready1, out1, cout1, zero1, neg1, ovf1},
            {1'b1, 1'b0, 8'h46, 4'b0000});
    end
    @(negedge clk);
    in_valid1 = 0; out_ready1 = 1;
    @(posedge clk); #1;
    out_ready1 = 0;
    check("bp.release", {in_ready1, out_valid1}, 2'b10);
    @(posedge clk); #1;
    check("bp.no_capture", {in_ready1, out_valid1}, 2'b10);

    // Reset in the middle of a multiply
    @(negedge clk);
    fun = 3'b111; a = 8'h10; b = 8'h11; cin = 0; in_valid1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.valid", {out_valid1, in_ready1}, 2'b01);
    check("rst_mid.out", {out1, cout1, zero1, neg1, ovf1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid.ready", in_ready1, 1);
    run_op("post_rst",  1, 3'b000, 8'h01, 8'h02, 0, 8'h03, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
